// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding, tag prefix
// and default stall limit. The TAG state exists only when UART_ARB_TAG_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3
`ifdef UART_ARB_TAG_EN
    ,
    ST_TAG   = 3'd4
`endif
  } arb_state_e;

  localparam logic [3:0] TAG_PREFIX       = 4'hA;
  localparam int         IDLE_TMO_DEFAULT = 65535;

  // Tag byte announcing which requester owns the following packet.
  function automatic logic [7:0] make_tag(input logic [2:0] gnt);
    return {TAG_PREFIX, 1'b0, gnt};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index after last_gnt_i,
// searching upward modulo NREQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      last_gnt_i,
  output logic [2:0]      idx_o,
  output logic            any_req_o
);

  logic [7:0] req_pad_s;
  logic [3:0] sum_s;
  logic [3:0] cand_s;
  logic       hit_s;
  logic       found_s;
  logic [2:0] idx_s;

  // Scan offsets 1..NREQ from the previous winner; the first hit wins.
  always_comb begin
    req_pad_s            = 8'h00;
    req_pad_s[NREQ-1:0]  = req_i;
    sum_s                = 4'h0;
    cand_s               = 4'h0;
    hit_s                = 1'b0;
    found_s              = 1'b0;
    idx_s                = last_gnt_i;
    for (int k = 1; k <= NREQ; k++) begin
      sum_s   = {1'b0, last_gnt_i} + 4'(k);
      cand_s  = (sum_s >= 4'(NREQ)) ? (sum_s - 4'(NREQ)) : sum_s;
      hit_s   = !found_s && req_pad_s[cand_s[2:0]];
      idx_s   = hit_s ? cand_s[2:0] : idx_s;
      found_s = found_s | hit_s;
    end
  end

  assign idx_o     = idx_s;
  assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one UART transmitter byte by byte.
// Define UART_ARB_TAG_EN to prefix every packet with a {4'hA, 1'b0, gnt_id} tag byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDLE_TMO = IDLE_TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_rdy,
  output logic              uart_tx_vld,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_txrdy,
  output logic              busy,
  output logic [2:0]        gnt_id,
  output logic              tmo_err
);

  localparam logic [15:0]     TMO_LAST = 16'(IDLE_TMO - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e        state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        last_gnt_q, last_gnt_d;
  logic              last_flag_q, last_flag_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]   req_rdy_q, req_rdy_d;
  logic              tx_vld_q, tx_vld_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;

  logic [2:0]        pick_s;
  logic              any_s;
  logic [7:0]        vld_pad_s;
  logic [7:0]        last_pad_s;
  logic [7:0][7:0]   data_pad_s;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i      (req_vld),
    .last_gnt_i (last_gnt_q),
    .idx_o      (pick_s),
    .any_req_o  (any_s)
  );

  // Widen per-requester inputs to 8 lanes so the 3-bit grant indexes them directly.
  always_comb begin
    vld_pad_s            = 8'h00;
    last_pad_s           = 8'h00;
    data_pad_s           = 64'h0;
    vld_pad_s[NREQ-1:0]  = req_vld;
    last_pad_s[NREQ-1:0] = req_last;
    for (int i = 0; i < NREQ; i++) begin
      data_pad_s[i] = req_data[8*i +: 8];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 3'd0;
      last_gnt_q  <= LAST_IDX;
      last_flag_q <= 1'b0;
      cnt_q       <= 16'h0000;
      req_rdy_q   <= {NREQ{1'b0}};
      tx_vld_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      last_flag_q <= last_flag_d;
      cnt_q       <= cnt_d;
      req_rdy_q   <= req_rdy_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state logic; the grant is held until the last byte or a stall timeout.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    last_flag_d = last_flag_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_s && uart_txrdy) begin
          gnt_d = pick_s;
          cnt_d = 16'h0000;
`ifdef UART_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_XFER;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        last_flag_d = 1'b0;
        state_d     = ST_PULSE;
      end
`endif
      ST_XFER: begin
        if (vld_pad_s[gnt_q]) begin
          last_flag_d = last_pad_s[gnt_q];
          state_d     = ST_PULSE;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d      = cnt_q + 16'h0001;
          tmo_d      = 1'b1;
          last_gnt_d = gnt_q;
          state_d    = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 16'h0001;
          state_d = ST_XFER;
        end
      end
      ST_PULSE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (uart_txrdy) begin
          if (last_flag_q) begin
            last_gnt_d = gnt_q;
            state_d    = ST_IDLE;
          end else begin
            cnt_d   = 16'h0000;
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without extra latency.
  always_comb begin
    tx_vld_d = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_XFER: req_rdy_d = ONE_HOT0 << gnt_d;
      default: req_rdy_d = {NREQ{1'b0}};
    endcase
    if ((state_q == ST_XFER) && (state_d == ST_PULSE)) begin
      tx_data_d = data_pad_s[gnt_q];
    end
`ifdef UART_ARB_TAG_EN
    else if (state_q == ST_TAG) begin
      tx_data_d = make_tag(gnt_q);
    end
`endif
    else begin
      tx_data_d = tx_data_q;
    end
  end

  assign req_rdy      = req_rdy_q;
  assign uart_tx_vld  = tx_vld_q;
  assign uart_tx_data = tx_data_q;
  assign busy         = busy_q;
  assign gnt_id       = gnt_q;
  assign tmo_err      = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester byte queues, a UART timing model
// and a round-robin/packet-lock scoreboard. Honors UART_ARB_TAG_EN like the design.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 8;
  localparam int QD   = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_vld;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_rdy;
  logic              uart_tx_vld;
  logic [7:0]        uart_tx_data;
  logic              uart_txrdy;
  logic              busy;
  logic [2:0]        gnt_id;
  logic              tmo_err;

  uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .uart_tx_vld(uart_tx_vld), .uart_tx_data(uart_tx_data),
    .uart_txrdy(uart_txrdy), .busy(busy), .gnt_id(gnt_id), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: per-requester byte queues {last, data} plus arbitration history.
  logic [8:0] mem [NREQ][QD];
  int  head [NREQ];
  int  tail [NREQ];
  bit  stall_after [NREQ];
  bit  stalled [NREQ];
  int  owner, last_m, gap_left, stall_cnt, frame_cnt;
  bit  pend_v, exp_tmo, saw_strobe;
  logic [7:0] pend_b;

  function automatic int rr_next();
    for (int k = 1; k <= NREQ; k++) begin
      int c = (last_m + k) % NREQ;
      if (head[c] != tail[c]) return c;
    end
    return -1;
  endfunction

  function automatic int pending_count();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += tail[i] - head[i];
    return s;
  endfunction

  task automatic push(input int i, input logic [7:0] b, input bit last);
    if (head[i] == tail[i]) begin head[i] = 0; tail[i] = 0; end
    mem[i][tail[i]] = {last, b};
    tail[i]++;
  endtask

  task automatic model_reset();
    owner = -1; last_m = NREQ - 1; gap_left = 0; stall_cnt = 0; frame_cnt = 0;
    pend_v = 0; exp_tmo = 0; saw_strobe = 0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0; tail[i] = 0; stall_after[i] = 0; stalled[i] = 0;
    end
  endtask

  // One clock: observe outputs at the falling edge, score them, then drive next inputs.
  task automatic step();
    int r;
    logic [NREQ-1:0] vld_v;
    logic [8:0] ent;
    @(negedge clk);
    check_eq("tmo_err", 32'(tmo_err), 32'(exp_tmo));
    exp_tmo = 0;
    saw_strobe = uart_tx_vld;
    if (uart_tx_vld) begin
      check_eq("uart_idle_at_strobe", 32'(uart_txrdy), 32'd1);
      if (pend_v) check_eq("strobe_data", 32'(uart_tx_data), 32'(pend_b));
`ifdef UART_ARB_TAG_EN
      else if (owner < 0) begin
        r = rr_next();
        check_eq("tag_byte", 32'(uart_tx_data), 32'(8'hA0 | r[7:0]));
        check_eq("tag_gnt_id", 32'(gnt_id), 32'(r));
        owner = r;
      end
`endif
      else check_eq("spurious_strobe", 32'(uart_tx_vld), 32'd0);
    end else if (pend_v) begin
      check_eq("strobe_latency", 32'(uart_tx_vld), 32'd1);
    end
    pend_v = 0;
    // UART: busy for frame_cnt cycles starting the cycle after a strobe.
    uart_txrdy = (frame_cnt == 0);
    if (frame_cnt > 0) frame_cnt--;
    if (uart_tx_vld) frame_cnt = $urandom_range(6, 2);
    r = -1;
    if (req_rdy != '0) begin
      for (int i = 0; i < NREQ; i++) if (req_rdy[i]) r = i;
      check_eq("rdy_onehot", 32'($countones(req_rdy)), 32'd1);
      if (owner < 0) begin
        check_eq("rr_grant", 32'(r), 32'(rr_next()));
        owner = r;
      end else begin
        check_eq("packet_lock", 32'(r), 32'(owner));
      end
      check_eq("gnt_id", 32'(gnt_id), 32'(r));
    end else begin
      stall_cnt = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      ent = (head[i] != tail[i]) ? mem[i][head[i]] : 9'h000;
      vld_v[i] = (head[i] != tail[i]) && !stalled[i] && !((i == owner) && (gap_left > 0));
      req_data[8*i +: 8] = ent[7:0];
      req_last[i] = ent[8];
    end
    if (gap_left > 0) gap_left--;
    req_vld = vld_v;
    if (r >= 0) begin
      if (vld_v[r]) begin
        ent = mem[r][head[r]];
        head[r]++;
        pend_v = 1; pend_b = ent[7:0]; stall_cnt = 0;
        if (ent[8]) begin
          owner = -1; last_m = r;
        end else begin
          gap_left = $urandom_range(3, 0);
          if (stall_after[r]) stalled[r] = 1;
        end
      end else begin
        stall_cnt++;
        if (stall_cnt == TMO) begin
          exp_tmo = 1; owner = -1; last_m = r;
          head[r] = tail[r]; stalled[r] = 0; stall_cnt = 0;
        end
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((pending_count() > 0 || owner >= 0 || frame_cnt > 0 || pend_v || exp_tmo) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    check_eq("queues_drained", 32'(pending_count()), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    check_eq({tag, "_tx_vld"}, 32'(uart_tx_vld), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(uart_tx_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_tmo_err"}, 32'(tmo_err), 32'd0);
    check_eq({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_data = '0; req_last = '0; uart_txrdy = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single requester, three-byte packet.
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    run_until_idle(500);

    // Two contenders: requester 1 must win and finish before requester 3.
    push(1, 8'h81, 0); push(1, 8'h82, 1);
    push(3, 8'hC1, 0); push(3, 8'hC2, 1);
    run_until_idle(500);

    // Requester 2 stalls after its first byte; requester 3 takes over after the timeout.
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    stall_after[2] = 1;
    push(3, 8'h3F, 1);
    run_until_idle(500);

    // Reset while waiting on the UART abandons the packet.
    push(0, 8'hA1, 0); push(0, 8'hA2, 1);
    for (int n = 0; n < 100 && !saw_strobe; n++) step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_in_wait");
    model_reset();
    req_vld = '0; req_last = '0; uart_txrdy = 1'b1;
    rst = 1'b0;
    repeat (20) step();

    // Four requesters with back-to-back one-byte packets: 0,1,2,3,0,...
    for (int rnd = 0; rnd < 2; rnd++)
      for (int i = 0; i < NREQ; i++) push(i, 8'(8'h40 + 16 * rnd + i), 1);
    run_until_idle(1000);

    // Randomized packets with mid-packet gaps shorter than the stall limit.
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int i = 0; i < NREQ; i++) begin
        int len;
        if ($urandom_range(3, 0) != 0) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
      end
      run_until_idle(2000);
    end

    // Single-byte packet from requester 2 (tagged as 8'hA2 when tags are enabled).
    push(2, 8'h5C, 1);
    run_until_idle(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter IDLE_TMO, default 65535, mid-packet stall limit in clk cycles (legal 1..65535).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_vld  input  NREQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*NREQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NREQ  marks final byte of packet, qualified by req_vld.
REQ-008 SHALL have port req_rdy  output  NREQ  byte accepted when req_vld[i] & req_rdy[i].
REQ-009 SHALL have port uart_tx_vld  output  1  single-cycle send strobe to UART transmitter.
REQ-010 SHALL have port uart_tx_data  output  8  byte to UART, stable from the strobe until the next strobe.
REQ-011 SHALL have port uart_txrdy  input  1  UART idle; drops the cycle after a strobe, rises at end of frame.
REQ-012 SHALL have ports busy  output  1  packet in progress; gnt_id  output  3  current/last grant index; tmo_err  output  1  one-cycle stall-timeout pulse.

Function
REQ-013 SHALL implement FSM states IDLE, XFER, PULSE, WAIT (plus TAG when UART_ARB_TAG_EN is defined).
REQ-014 IDLE: when any req_vld is 1 and uart_txrdy is 1, SHALL grant the first requesting index searching last_gnt+1, last_gnt+2, ... modulo NREQ, register gnt_id, and go to XFER (TAG if enabled).
REQ-015 XFER: req_rdy[gnt_id] SHALL be 1 and all other req_rdy 0; on handshake, register byte into uart_tx_data, register req_last into last_flag, and go to PULSE.
REQ-016 PULSE: uart_tx_vld SHALL be 1 for exactly this one cycle; the next state is always WAIT (uart_txrdy ignored in PULSE).
REQ-017 WAIT: SHALL remain until uart_txrdy is 1; then go to IDLE with last_gnt<=gnt_id if last_flag, else XFER.
REQ-018 Latency: handshake in cycle N SHALL give uart_tx_vld in N+1; uart_txrdy sampled from N+2.
REQ-019 req_rdy SHALL be all-zero in IDLE, TAG, PULSE, WAIT; uart_tx_vld SHALL be 0 outside PULSE.
REQ-020 Packet lock: grant SHALL NOT change until the req_last byte completes or a timeout occurs; other requesters wait.
REQ-021 Stall timeout: 16-bit counter cleared on XFER entry, increments each XFER cycle with req_vld[gnt_id]=0; on reaching IDLE_TMO SHALL pulse tmo_err, set last_gnt<=gnt_id, go to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Single-byte packet (req_last on first byte) SHALL be legal and release the grant after its WAIT.

Reset
REQ-024 On rst: state IDLE, req_rdy 0, uart_tx_vld 0, uart_tx_data 8'h00, busy 0, tmo_err 0, gnt_id 0, last_gnt NREQ-1 (requester 0 first priority), timeout counter 0, last_flag 0.
REQ-025 Reset mid-packet SHALL abandon the packet with no further strobes; the UART frame already in flight is not this block's concern.

Configuration
REQ-026 Macro UART_ARB_TAG_EN: when defined, after grant the FSM SHALL enter TAG, load uart_tx_data = {4'hA, 1'b0, gnt_id}, go to PULSE/WAIT, then XFER; the tag never ends a packet.
REQ-027 Without UART_ARB_TAG_EN: no TAG state, no tag byte; grant goes directly to XFER.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encoding, TAG_PREFIX (4'hA), and the default IDLE_TMO value.
REQ-029 Round-robin selection SHALL be a sub-module rr_pick (inputs request vector, last_gnt; output index and any_req), purely combinational.

Verification
REQ-030 Single requester 0 sends 3 bytes 8'h11,8'h22,8'h33 (last on 8'h33) -> three uart_tx_vld strobes carrying those bytes in order, each only after uart_txrdy returns high; busy low afterwards.
REQ-031 Requesters 1 and 3 both valid from IDLE after reset -> requester 1 granted first; its whole packet completes before requester 3's first byte.
REQ-032 All four requesters continuously sending 1-byte packets -> grant order 0,1,2,3,0 with no requester starved.
REQ-033 Requester 2 drops req_vld mid-packet with IDLE_TMO=8 -> tmo_err one-cycle pulse 8 XFER cycles later, grant moves to next requesting index.
REQ-034 rst asserted in WAIT -> next cycle all outputs at reset values, no strobe until a fresh grant.
REQ-035 UART_ARB_TAG_EN defined, requester 2 sends 8'h5C (last) -> strobes 8'hA2 then 8'h5C.
